// File: rtl/mem_stage_lsu.sv
`timescale 1ns/1ps
// MEM-stage load/store unit: launches one aligned memory request per load/store,
// holds the pipeline until ack or timeout, and returns the size/sign-extended load data.
module mem_stage_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        riscv_start,
    input  logic        riscv_done,
    input  logic        ex_mem_mem_read,
    input  logic        ex_mem_mem_write,
    input  logic [2:0]  ex_mem_funct3,
    input  logic [31:0] ex_mem_alu_result,
    input  logic [31:0] ex_mem_write_data,
    output logic [31:0] mem_read_data,
    output logic        dcache_stall,
    output logic        misaligned,
    output logic        mem_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic          err_q, err_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [2:0]    f3_q, f3_d;
    logic [1:0]    off_q, off_d;

    logic        access, is_half, is_word, valid;
    logic [3:0]  st_strb;
    logic [31:0] st_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    assign access     = ex_mem_mem_read | ex_mem_mem_write;
    assign is_half    = (ex_mem_funct3[1:0] == 2'b01);
    assign is_word    = (ex_mem_funct3[1:0] == 2'b10);
    assign misaligned = access & ((is_half & ex_mem_alu_result[0]) |
                                  (is_word & (ex_mem_alu_result[1:0] != 2'b00)));
    assign valid      = access & riscv_start & ~riscv_done & ~misaligned;

    assign dcache_stall = ((state_q == S_IDLE) & valid) | (state_q == S_REQ);

    always_comb begin
        case (ex_mem_funct3[1:0])
            2'b00: begin
                st_strb = 4'b0001 << ex_mem_alu_result[1:0];
                st_data = {4{ex_mem_write_data[7:0]}};
            end
            2'b01: begin
                st_strb = 4'b0011 << ex_mem_alu_result[1:0];
                st_data = {2{ex_mem_write_data[15:0]}};
            end
            default: begin
                st_strb = 4'b1111;
                st_data = ex_mem_write_data;
            end
        endcase
    end

    // Size/offset are captured at launch so extension does not depend on the EX/MEM latch.
    always_comb begin
        case (off_q)
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (f3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'd0, ld_byte};
            3'b101:  ld_ext = {16'd0, ld_half};
            default: ld_ext = mem_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        err_d   = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rdata_d = rdata_q;
        f3_d    = f3_q;
        off_d   = off_q;
        case (state_q)
            S_IDLE: begin
                if (valid) begin
                    state_d = S_REQ;
                    cnt_d   = '0;
                    req_d   = 1'b1;
                    we_d    = ~ex_mem_mem_read & ex_mem_mem_write;
                    addr_d  = {ex_mem_alu_result[31:2], 2'b00};
                    wdata_d = ex_mem_mem_read ? '0 : st_data;
                    wstrb_d = ex_mem_mem_read ? '0 : st_strb;
                    f3_d    = ex_mem_funct3;
                    off_d   = ex_mem_alu_result[1:0];
                end else if (ex_mem_mem_read & misaligned & riscv_start & ~riscv_done) begin
                    rdata_d = '0;
                end
            end
            S_REQ: begin
                if (mem_ack) begin
                    state_d = S_DONE;
                    req_d   = 1'b0;
                    if (!we_q) begin
                        rdata_d = ld_ext;
                    end
                end else if (cnt_q >= CNT_LAST) begin
                    state_d = S_DONE;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            f3_q    <= '0;
            off_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
        end
    end

    assign mem_read_data = rdata_q;
    assign mem_err       = err_q;
    assign mem_req       = req_q;
    assign mem_we        = we_q;
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign mem_wstrb     = wstrb_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
`timescale 1ns/1ps
// Bench for mem_stage_lsu: transaction-level model checked every cycle on the
// falling edge, plus directed scenarios with hand-computed literal expectations.
module tb_mem_stage_lsu;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        riscv_start, riscv_done;
    logic        ex_mem_mem_read, ex_mem_mem_write;
    logic [2:0]  ex_mem_funct3;
    logic [31:0] ex_mem_alu_result, ex_mem_write_data;
    logic [31:0] mem_read_data;
    logic        dcache_stall, misaligned, mem_err, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int errors = 0;
    int checks = 0;

    mem_stage_lsu #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset),
        .riscv_start(riscv_start), .riscv_done(riscv_done),
        .ex_mem_mem_read(ex_mem_mem_read), .ex_mem_mem_write(ex_mem_mem_write),
        .ex_mem_funct3(ex_mem_funct3), .ex_mem_alu_result(ex_mem_alu_result),
        .ex_mem_write_data(ex_mem_write_data), .mem_read_data(mem_read_data),
        .dcache_stall(dcache_stall), .misaligned(misaligned), .mem_err(mem_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int m_nbytes(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] m_extend(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
        int unsigned n;
        logic [31:0] v, span;
        if (f3 == 3'b000 || f3 == 3'b100) n = 1;
        else if (f3 == 3'b001 || f3 == 3'b101) n = 2;
        else return w;
        span = 32'd1 << (8 * n);
        v = (w >> (8 * int'(off))) % span;
        if (f3[2] == 1'b0 && v >= span / 2) v = v - span;
        return v;
    endfunction

    function automatic logic [3:0] m_strobe(input logic [2:0] f3, input logic [1:0] off);
        int n = m_nbytes(f3);
        if (n == 4) return 4'hF;
        return 4'(((1 << n) - 1) << int'(off));
    endfunction

    function automatic logic [31:0] m_lanes(input logic [2:0] f3, input logic [31:0] wd);
        int n = m_nbytes(f3);
        logic [31:0] v = '0;
        if (n == 4) return wd;
        for (int i = 0; i < 4 / n; i++)
            v = v | ((wd % (32'd1 << (8 * n))) << (8 * n * i));
        return v;
    endfunction

    function automatic logic m_mis(input logic rd, input logic wr, input logic [2:0] f3,
                                   input logic [31:0] a);
        if (!(rd || wr)) return 1'b0;
        if (f3[1:0] == 2'b01) return (a % 2) != 0;
        if (f3[1:0] == 2'b10) return (a % 4) != 0;
        return 1'b0;
    endfunction

    bit          m_ok = 0, m_busy = 0, m_done = 0;
    int          m_cyc = 0;
    logic        m_req, m_we, m_err;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_strb;
    logic [2:0]  m_f3;
    logic [1:0]  m_off;

    always @(posedge clk) begin
        if (reset) begin
            m_ok = 1; m_busy = 0; m_done = 0; m_cyc = 0;
            m_req = 0; m_we = 0; m_err = 0;
            m_addr = '0; m_wdata = '0; m_rdata = '0; m_strb = '0;
            m_f3 = '0; m_off = '0;
        end else if (m_ok) begin
            m_err = 0;
            if (m_done) begin
                m_done = 0;
            end else if (m_busy) begin
                m_cyc++;
                if (mem_ack) begin
                    m_busy = 0; m_done = 1; m_req = 0;
                    if (!m_we) m_rdata = m_extend(m_f3, m_off, mem_rdata);
                end else if (m_cyc == T) begin
                    m_busy = 0; m_done = 1; m_req = 0; m_err = 1; m_rdata = '0;
                end
            end else if ((ex_mem_mem_read || ex_mem_mem_write) && riscv_start && !riscv_done) begin
                if (m_mis(ex_mem_mem_read, ex_mem_mem_write, ex_mem_funct3, ex_mem_alu_result)) begin
                    if (ex_mem_mem_read) m_rdata = '0;
                end else begin
                    m_busy = 1; m_cyc = 0; m_req = 1;
                    m_we    = ex_mem_mem_write && !ex_mem_mem_read;
                    m_addr  = ex_mem_alu_result - (ex_mem_alu_result % 4);
                    m_strb  = ex_mem_mem_read ? 4'h0 : m_strobe(ex_mem_funct3, ex_mem_alu_result[1:0]);
                    m_wdata = ex_mem_mem_read ? '0 : m_lanes(ex_mem_funct3, ex_mem_write_data);
                    m_f3    = ex_mem_funct3;
                    m_off   = ex_mem_alu_result[1:0];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            logic mis_now, valid_now;
            mis_now   = m_mis(ex_mem_mem_read, ex_mem_mem_write, ex_mem_funct3, ex_mem_alu_result);
            valid_now = (ex_mem_mem_read || ex_mem_mem_write) && riscv_start && !riscv_done && !mis_now;
            chk("m_req",   32'(mem_req),   32'(m_req));
            chk("m_err",   32'(mem_err),   32'(m_err));
            chk("m_rdata", mem_read_data,  m_rdata);
            chk("m_stall", 32'(dcache_stall), 32'(m_busy || (!m_done && valid_now)));
            chk("m_mis",   32'(misaligned), 32'(mis_now));
            if (m_busy) begin
                chk("m_we",    32'(mem_we),    32'(m_we));
                chk("m_addr",  mem_addr,       m_addr);
                chk("m_wdata", mem_wdata,      m_wdata);
                chk("m_wstrb", 32'(mem_wstrb), 32'(m_strb));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                           input logic also_wr, input logic [31:0] rd_word, input int wait_cyc,
                           input logic [31:0] exp);
        step();
        ex_mem_mem_read = 1; ex_mem_mem_write = also_wr; ex_mem_funct3 = f3; ex_mem_alu_result = a;
        @(negedge clk);
        chk({name, "_stall"}, 32'(dcache_stall), 32'd1);
        for (int i = 0; i < wait_cyc; i++) step();
        step();
        mem_ack = 1; mem_rdata = rd_word;
        @(negedge clk);
        chk({name, "_req"}, 32'(mem_req), 32'd1);
        chk({name, "_we"}, 32'(mem_we), 32'd0);
        chk({name, "_strb"}, 32'(mem_wstrb), 32'd0);
        step();
        mem_ack = 0; ex_mem_mem_read = 0; ex_mem_mem_write = 0;
        @(negedge clk);
        chk({name, "_data"}, mem_read_data, exp);
    endtask

    task automatic store_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] ea, input logic [3:0] es,
                            input logic [31:0] ew);
        step();
        ex_mem_mem_write = 1; ex_mem_funct3 = f3; ex_mem_alu_result = a; ex_mem_write_data = wd;
        step();
        mem_ack = 1;
        @(negedge clk);
        chk({name, "_req"}, 32'(mem_req), 32'd1);
        chk({name, "_we"}, 32'(mem_we), 32'd1);
        chk({name, "_addr"}, mem_addr, ea);
        chk({name, "_strb"}, 32'(mem_wstrb), 32'(es));
        chk({name, "_wdata"}, mem_wdata, ew);
        step();
        mem_ack = 0; ex_mem_mem_write = 0;
        @(negedge clk);
        chk({name, "_done"}, 32'(mem_req), 32'd0);
    endtask

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; riscv_start = 0; riscv_done = 0;
        ex_mem_mem_read = 0; ex_mem_mem_write = 0; ex_mem_funct3 = 0;
        ex_mem_alu_result = 0; ex_mem_write_data = 0; mem_ack = 0; mem_rdata = 0;
        step(); step();
        reset = 0; riscv_start = 1;
        @(negedge clk);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_data", mem_read_data, 32'd0);
        chk("rst_stall", 32'(dcache_stall), 32'd0);
        chk("rst_strb", 32'(mem_wstrb), 32'd0);

        // LB 0x103, ack on third REQ cycle: stall high four cycles
        step();
        ex_mem_mem_read = 1; ex_mem_funct3 = 3'b000; ex_mem_alu_result = 32'h103;
        @(negedge clk);
        chk("lb_stall0", 32'(dcache_stall), 32'd1);
        chk("lb_req0", 32'(mem_req), 32'd0);
        for (int i = 1; i <= 3; i++) begin
            step();
            if (i == 3) begin mem_ack = 1; mem_rdata = 32'h80FF_FF00; end
            @(negedge clk);
            chk("lb_stall", 32'(dcache_stall), 32'd1);
            chk("lb_req", 32'(mem_req), 32'd1);
            chk("lb_addr", mem_addr, 32'h100);
        end
        step();
        mem_ack = 0; ex_mem_mem_read = 0;
        @(negedge clk);
        chk("lb_stall_done", 32'(dcache_stall), 32'd0);
        chk("lb_data", mem_read_data, 32'hFFFF_FF80);
        chk("lb_req_done", 32'(mem_req), 32'd0);

        store_op("sh", 3'b001, 32'h202, 32'h0000_BEEF, 32'h200, 4'b1100, 32'hBEEF_BEEF);
        store_op("sb", 3'b000, 32'h001, 32'h0000_00A5, 32'h000, 4'b0010, 32'hA5A5_A5A5);
        store_op("sw", 3'b010, 32'h014, 32'h1122_3344, 32'h014, 4'b1111, 32'h1122_3344);
        chk("st_keep_data", mem_read_data, 32'hFFFF_FF80);

        load_op("lbu", 3'b100, 32'h101, 0, 32'h0000_9A00, 0, 32'h0000_009A);
        load_op("lbp", 3'b000, 32'h002, 0, 32'h007F_0000, 1, 32'h0000_007F);
        load_op("lh",  3'b001, 32'h000, 0, 32'h0000_8001, 0, 32'hFFFF_8001);
        load_op("lhu", 3'b101, 32'h002, 0, 32'h1234_5678, 2, 32'h0000_1234);
        load_op("f11", 3'b011, 32'h00C, 0, 32'hCAFE_F00D, 0, 32'hCAFE_F00D);
        load_op("rdwr", 3'b010, 32'h020, 1, 32'h55AA_55AA, 0, 32'h55AA_55AA);

        // misaligned LW
        step();
        ex_mem_mem_read = 1; ex_mem_funct3 = 3'b010; ex_mem_alu_result = 32'h005;
        @(negedge clk);
        chk("mis_flag", 32'(misaligned), 32'd1);
        chk("mis_stall", 32'(dcache_stall), 32'd0);
        chk("mis_req", 32'(mem_req), 32'd0);
        step();
        ex_mem_mem_read = 0;
        @(negedge clk);
        chk("mis_data", mem_read_data, 32'd0);
        chk("mis_req2", 32'(mem_req), 32'd0);

        load_op("lw", 3'b010, 32'h008, 0, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF);

        // timeout: no ack, mem_req exactly T cycles
        step();
        ex_mem_mem_read = 1; ex_mem_funct3 = 3'b010; ex_mem_alu_result = 32'h010;
        for (int i = 1; i <= T; i++) begin
            step();
            @(negedge clk);
            chk("to_req", 32'(mem_req), 32'd1);
            chk("to_err_early", 32'(mem_err), 32'd0);
        end
        step();
        ex_mem_mem_read = 0;
        @(negedge clk);
        chk("to_req_drop", 32'(mem_req), 32'd0);
        chk("to_err", 32'(mem_err), 32'd1);
        chk("to_data", mem_read_data, 32'd0);
        step();
        @(negedge clk);
        chk("to_err_pulse", 32'(mem_err), 32'd0);
        chk("to_idle_stall", 32'(dcache_stall), 32'd0);

        // reset mid-REQ, then stray ack
        load_op("pre", 3'b010, 32'h018, 0, 32'h0000_0777, 0, 32'h0000_0777);
        step();
        ex_mem_mem_read = 1; ex_mem_funct3 = 3'b010; ex_mem_alu_result = 32'h030;
        step();
        reset = 1;
        @(negedge clk);
        chk("rr_req_before", 32'(mem_req), 32'd1);
        step();
        reset = 0; ex_mem_mem_read = 0;
        @(negedge clk);
        chk("rr_req", 32'(mem_req), 32'd0);
        chk("rr_stall", 32'(dcache_stall), 32'd0);
        chk("rr_err", 32'(mem_err), 32'd0);
        chk("rr_data", mem_read_data, 32'd0);
        step();
        mem_ack = 1; mem_rdata = 32'hFFFF_FFFF;
        step();
        mem_ack = 0;
        @(negedge clk);
        chk("stray_data", mem_read_data, 32'd0);
        chk("stray_req", 32'(mem_req), 32'd0);
        chk("stray_err", 32'(mem_err), 32'd0);

        // riscv_done rises during REQ
        step();
        ex_mem_mem_read = 1; ex_mem_funct3 = 3'b010; ex_mem_alu_result = 32'h040;
        step();
        riscv_done = 1;
        @(negedge clk);
        chk("dn_req", 32'(mem_req), 32'd1);
        step();
        mem_ack = 1; mem_rdata = 32'h0BAD_F00D;
        step();
        mem_ack = 0; ex_mem_alu_result = 32'h044;
        @(negedge clk);
        chk("dn_data", mem_read_data, 32'h0BAD_F00D);
        chk("dn_stall_done", 32'(dcache_stall), 32'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            @(negedge clk);
            chk("dn_next_stall", 32'(dcache_stall), 32'd0);
            chk("dn_next_req", 32'(mem_req), 32'd0);
        end
        step();
        riscv_done = 0; riscv_start = 0;
        step();
        @(negedge clk);
        chk("ns_stall", 32'(dcache_stall), 32'd0);
        chk("ns_req", 32'(mem_req), 32'd0);
        ex_mem_mem_read = 0; riscv_start = 1;
        step(); step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255, giving the maximum number of cycles mem_req waits for mem_ack before the access is abandoned.
REQ-002 clk  in  1  clock; all state changes on the rising edge.
REQ-003 reset  in  1  reset, synchronous, active-high; clock clk.
REQ-004 riscv_start  in  1  core run enable.
REQ-005 riscv_done  in  1  core finished; no new access is launched while high.
REQ-006 ex_mem_mem_read, ex_mem_mem_write  in  1 each  load or store request from the EX/MEM latch.
REQ-007 ex_mem_funct3  in  3  access size and sign.
REQ-008 ex_mem_alu_result  in  32  byte address.
REQ-009 ex_mem_write_data  in  32  store data, right-aligned.
REQ-010 mem_read_data  out  32  extended load result, registered.
REQ-011 dcache_stall  out  1  pipeline hold for the EX/MEM and MEM/WB latches.
REQ-012 misaligned  out  1  misaligned access flag, combinational.
REQ-013 mem_err  out  1  timeout pulse, registered.
REQ-014 mem_req, mem_we  out  1 each  memory request and write enable, registered.
REQ-015 mem_addr  out  32  word address, with bits [1:0] = 0.
REQ-016 mem_wdata  out  32  lane-shifted store data.
REQ-017 mem_wstrb  out  4  byte enables; 0 for reads.
REQ-018 mem_ack  in  1  memory completion strobe.
REQ-019 mem_rdata  in  32  read word, valid with mem_ack.

Function
REQ-020 The FSM SHALL have the states IDLE, REQ and DONE.
REQ-021 A valid access SHALL be defined as (read or write) AND riscv_start AND NOT riscv_done AND NOT misaligned.
REQ-022 IDLE: on a valid access, the FSM SHALL go to REQ on the next edge, registering mem_addr, mem_we, mem_wdata and mem_wstrb, and asserting mem_req.
REQ-023 REQ: mem_req and all request fields SHALL stay stable until mem_ack is sampled high.
REQ-024 REQ with mem_ack high: the FSM SHALL go to DONE, drop mem_req on the same edge, and register the extended mem_rdata into mem_read_data (reads only).
REQ-025 REQ with the timeout counter reaching TIMEOUT_CYCLES and no ack: the FSM SHALL go to DONE, drop mem_req, pulse mem_err for 1 cycle, and set mem_read_data = 0.
REQ-026 DONE SHALL return to IDLE unconditionally after 1 cycle.
REQ-027 dcache_stall SHALL be high when (state = IDLE and valid access) or state = REQ, and low in DONE, so that MEM/WB captures mem_read_data at the DONE edge.
REQ-028 Minimum load latency SHALL be 3 cycles: request visible in IDLE, mem_req the next cycle, ack in the same cycle, then DONE.
REQ-029 The timeout counter SHALL clear on entry to REQ, increment each REQ cycle, and saturate.
REQ-030 Load extension SHALL be: funct3 000 LB sign-extend; 001 LH sign-extend; 010 LW; 100 LBU zero-extend; 101 LHU zero-extend; any other code returns the full word.
REQ-031 Store lanes SHALL be: funct3 000 SB wstrb = 0001 << addr[1:0], data byte replicated x4; 001 SH wstrb = 0011 << addr[1:0], halfword replicated x2; 010 SW wstrb = 1111.
REQ-032 Misalignment SHALL be defined as a halfword access with addr[0] = 1, or a word access with addr[1:0] ≠ 0.
REQ-033 A misaligned access SHALL assert misaligned, issue no request, and leave stall low; for a load, mem_read_data SHALL be 0 at the next edge.
REQ-034 Read and write asserted together SHALL be treated as a read, with mem_we = 0.
REQ-035 When no access is present, mem_read_data SHALL hold its last value.
REQ-036 An access already in flight SHALL complete even if riscv_start falls or riscv_done rises.
REQ-037 mem_ack sampled outside REQ SHALL be ignored.

Reset
REQ-038 On reset, the FSM SHALL go to IDLE, the timeout counter to 0, and mem_req, mem_we, mem_err, mem_addr, mem_wdata, mem_wstrb and mem_read_data to 0.
REQ-039 Reset SHALL take effect at the next edge in any state, including mid-REQ, abandoning the access with no mem_err pulse.

Verification
REQ-040 The bench SHALL cover: LB at addr 0x103, rdata 0x80FF_FF00, ack after 2 cycles -> mem_read_data = 0xFFFF_FF80 in DONE; stall high for 4 cycles, then low.
REQ-041 The bench SHALL cover: SH at 0x202, data 0x0000_BEEF -> mem_addr 0x200, wstrb 1100, wdata 0xBEEF_BEEF, mem_we 1.
REQ-042 The bench SHALL cover: LW at 0x005 -> misaligned 1, mem_req stays 0, stall 0, mem_read_data 0.
REQ-043 The bench SHALL cover: load with no ack and TIMEOUT_CYCLES = 4 -> mem_req held exactly 4 cycles, then mem_err pulse, mem_read_data 0, return to IDLE.
REQ-044 The bench SHALL cover: reset asserted during REQ -> next cycle mem_req 0, state IDLE; a later stray mem_ack causes no change.
REQ-045 The bench SHALL cover: riscv_done rising during REQ -> the access still completes; a following load is not launched (stall 0, mem_req 0).
